// File: rtl/mccu_quota_window_pkg.sv
// mccu_quota_window shared types and default widths.
// Imported by the interface, the per-core tracker and the top.
package mccu_quota_window_pkg;

    localparam int DATA_WIDTH_DEF   = 32;
    localparam int N_CORES_DEF      = 2;
    localparam int PERIOD_WIDTH_DEF = 32;
    localparam int OVR_WIDTH_DEF    = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_e;

endpackage

// File: rtl/mccu_quota_window_if.sv
// Signal bundle between software/MCCU side and the quota window stage.
// slave = the stage itself, master = whoever drives and observes it.
interface mccu_quota_window_if
    import mccu_quota_window_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int N_CORES      = N_CORES_DEF,
    parameter int PERIOD_WIDTH = PERIOD_WIDTH_DEF,
    parameter int OVR_WIDTH    = OVR_WIDTH_DEF
);

    logic                                enable_i;
    logic [PERIOD_WIDTH-1:0]             period_i;
    logic [N_CORES-1:0][DATA_WIDTH-1:0]  budget_i;
    logic [N_CORES-1:0][DATA_WIDTH-1:0]  quota_rem_i;
    logic [N_CORES-1:0]                  quota_irq_i;
    logic [N_CORES-1:0]                  irq_mask_i;
    logic [N_CORES-1:0]                  irq_ack_i;

    logic [N_CORES-1:0][DATA_WIDTH-1:0]  quota_o;
    logic                                mccu_enable_o;
    logic [N_CORES-1:0]                  irq_o;
    logic [N_CORES-1:0][DATA_WIDTH-1:0]  residual_o;
    logic [N_CORES-1:0][OVR_WIDTH-1:0]   overrun_cnt_o;
    logic                                window_start_o;

    modport slave (
        input  enable_i, period_i, budget_i,
        input  quota_rem_i, quota_irq_i,
        input  irq_mask_i, irq_ack_i,
        output quota_o, mccu_enable_o, irq_o,
        output residual_o, overrun_cnt_o, window_start_o
    );

    modport master (
        output enable_i, period_i, budget_i,
        output quota_rem_i, quota_irq_i,
        output irq_mask_i, irq_ack_i,
        input  quota_o, mccu_enable_o, irq_o,
        input  residual_o, overrun_cnt_o, window_start_o
    );

endinterface

// File: rtl/mccu_quota_core_track.sv
// Per-core interrupt and exhaustion bookkeeping for one quota window.
// Holds sticky pending, exhausted flag, residual and overrun counter.
module mccu_quota_core_track
    import mccu_quota_window_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int OVR_WIDTH  = OVR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  window_end,
    input  logic                  quota_irq,
    input  logic [DATA_WIDTH-1:0] quota_rem,
    input  logic                  ack,
    input  logic                  mask,
    output logic                  irq,
    output logic [DATA_WIDTH-1:0] residual,
    output logic [OVR_WIDTH-1:0]  overrun_cnt
);

    logic pending;
    logic exhausted;
    logic exhaust_now;

    // MCCU outputs are stale outside RUN, so only trust them there
    assign exhaust_now = run & (quota_irq | (quota_rem == '0));

    assign irq = pending & ~mask;

    // Sticky pending flag: a new interrupt beats a same-cycle ack
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (run && quota_irq) begin
            pending <= 1'b1;
        end else if (ack) begin
            pending <= 1'b0;
        end
    end

    // Exhausted-this-window flag, consumed at window end
    always_ff @(posedge clk) begin
        if (rst) begin
            exhausted <= 1'b0;
        end else if (window_end) begin
            exhausted <= 1'b0;
        end else if (exhaust_now) begin
            exhausted <= 1'b1;
        end
    end

    // Window-end snapshot of residual quota and saturating overrun count
    always_ff @(posedge clk) begin
        if (rst) begin
            residual    <= '0;
            overrun_cnt <= '0;
        end else if (window_end) begin
            residual <= quota_rem;
            if ((exhausted || exhaust_now) && (overrun_cnt != '1)) begin
                overrun_cnt <= overrun_cnt + OVR_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/mccu_quota_window.sv
// Periodic quota reload and interrupt management around the MCCU.
// Window = one LOAD cycle followed by period_q RUN cycles.
module mccu_quota_window
    import mccu_quota_window_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int N_CORES      = N_CORES_DEF,
    parameter int PERIOD_WIDTH = PERIOD_WIDTH_DEF,
    parameter int OVR_WIDTH    = OVR_WIDTH_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    mccu_quota_window_if.slave  qw
);

    state_e                             state;
    logic [PERIOD_WIDTH-1:0]            period_q;
    logic [PERIOD_WIDTH-1:0]            win_cnt;
    logic                               run;
    logic                               last;
    logic                               window_end;
    logic [N_CORES-1:0]                 irq;
    logic [N_CORES-1:0][DATA_WIDTH-1:0] residual;
    logic [N_CORES-1:0][OVR_WIDTH-1:0]  overrun;

    assign run  = (state == RUN);
    assign last = run && (period_q != '0)
               && (win_cnt == period_q - PERIOD_WIDTH'(1));

    // An enable drop on the last cycle aborts the window without update
    assign window_end = last & qw.enable_i;

    assign qw.irq_o         = irq;
    assign qw.residual_o    = residual;
    assign qw.overrun_cnt_o = overrun;

    // Window sequencer with registered MCCU enable and start pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state             <= IDLE;
            qw.mccu_enable_o  <= 1'b0;
            qw.window_start_o <= 1'b0;
            period_q          <= '0;
            win_cnt           <= '0;
        end else if (!qw.enable_i) begin
            state             <= IDLE;
            qw.mccu_enable_o  <= 1'b0;
            qw.window_start_o <= 1'b0;
            win_cnt           <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state             <= LOAD;
                    qw.mccu_enable_o  <= 1'b0;
                    qw.window_start_o <= 1'b1;
                    win_cnt           <= '0;
                end
                LOAD: begin
                    state             <= RUN;
                    qw.mccu_enable_o  <= 1'b1;
                    qw.window_start_o <= 1'b0;
                    period_q          <= qw.period_i;
                    win_cnt           <= '0;
                end
                RUN: begin
                    if (last) begin
                        state             <= LOAD;
                        qw.mccu_enable_o  <= 1'b0;
                        qw.window_start_o <= 1'b1;
                        win_cnt           <= '0;
                    end else begin
                        qw.mccu_enable_o  <= 1'b1;
                        qw.window_start_o <= 1'b0;
                        win_cnt           <= win_cnt + PERIOD_WIDTH'(1);
                    end
                end
                default: begin
                    state             <= IDLE;
                    qw.mccu_enable_o  <= 1'b0;
                    qw.window_start_o <= 1'b0;
                    win_cnt           <= '0;
                end
            endcase
        end
    end

    // Budget staging: MCCU picks this up while its enable is low
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            qw.quota_o <= '0;
        end else begin
            qw.quota_o <= qw.budget_i;
        end
    end

    for (genvar c = 0; c < N_CORES; c++) begin : g_core
        mccu_quota_core_track #(
            .DATA_WIDTH (DATA_WIDTH),
            .OVR_WIDTH  (OVR_WIDTH)
        ) u_track (
            .clk         (clk_i),
            .rst         (rst_i),
            .run         (run),
            .window_end  (window_end),
            .quota_irq   (qw.quota_irq_i[c]),
            .quota_rem   (qw.quota_rem_i[c]),
            .ack         (qw.irq_ack_i[c]),
            .mask        (qw.irq_mask_i[c]),
            .irq         (irq[c]),
            .residual    (residual[c]),
            .overrun_cnt (overrun[c])
        );
    end

endmodule
